// File: rtl/tcb_pkg.sv
// Shared TCB bus types and the fixed-priority port picker used by the decoder.
package tcb_pkg;

    // The request/response structs carry the SoC bus widths.
    localparam int unsigned TCB_AW = 32;
    localparam int unsigned TCB_DW = 32;
    localparam int unsigned TCB_BW = TCB_DW / 8;

    typedef struct packed {
        logic              wen;
        logic [TCB_BW-1:0] ben;
        logic [TCB_AW-1:0] adr;
        logic [TCB_DW-1:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [TCB_DW-1:0] rdt;
        logic              err;
    } tcb_rsp_t;

    // Lowest set bit wins; an empty vector returns 0 (caller flags unmapped).
    function automatic logic [3:0] tcb_dec_pri(input logic [15:0] hit);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (hit[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tcb_dec_np_if.sv
// Bus bundle between the upstream manager, the decoder and PN subordinates.
interface tcb_dec_np_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = DW / 8,
    parameter int unsigned PN = 4
);
    logic             sub_vld;
    logic             sub_wen;
    logic [BW-1:0]    sub_ben;
    logic [AW-1:0]    sub_adr;
    logic [DW-1:0]    sub_wdt;
    logic [DW-1:0]    sub_rdt;
    logic             sub_err;
    logic             sub_rdy;
    logic [PN-1:0]    man_vld;
    logic [PN-1:0]    man_wen;
    logic [PN*BW-1:0] man_ben;
    logic [PN*AW-1:0] man_adr;
    logic [PN*DW-1:0] man_wdt;
    logic [PN*DW-1:0] man_rdt;
    logic [PN-1:0]    man_err;
    logic [PN-1:0]    man_rdy;

    // Decoder side.
    modport slave (
        input  sub_vld, sub_wen, sub_ben, sub_adr, sub_wdt,
        output sub_rdt, sub_err, sub_rdy,
        output man_vld, man_wen, man_ben, man_adr, man_wdt,
        input  man_rdt, man_err, man_rdy
    );

    // Environment side: upstream manager plus the attached subordinates.
    modport master (
        output sub_vld, sub_wen, sub_ben, sub_adr, sub_wdt,
        input  sub_rdt, sub_err, sub_rdy,
        input  man_vld, man_wen, man_ben, man_adr, man_wdt,
        output man_rdt, man_err, man_rdy
    );
endinterface

// File: rtl/tcb_dly_pipe.sv
// Fixed-length shift register; DLY=0 is a wire.
module tcb_dly_pipe #(
    parameter int unsigned W   = 1,
    parameter int unsigned DLY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DLY == 0) begin : g_pass
        // Clock and reset have no role without stages.
        logic unused_clk_rst;
        assign unused_clk_rst = clk & rst;
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] stg [DLY];

        // Shift every cycle; reset clears all stages.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < DLY; i++) stg[i] <= '0;
            end else begin
                stg[0] <= d;
                for (int i = 1; i < DLY; i++) stg[i] <= stg[i-1];
            end
        end

        assign q = stg[DLY-1];
    end
endmodule

// File: rtl/tcb_dec_np.sv
// TCB address decoder: one subordinate port fanned out to PN manager ports,
// fixed response delay, built-in error responder and unmapped-access counter.
module tcb_dec_np
    import tcb_pkg::*;
#(
    parameter int unsigned           AW  = 32,
    parameter int unsigned           DW  = 32,
    parameter int unsigned           BW  = DW / 8,
    parameter int unsigned           PN  = 4,
    parameter int unsigned           DLY = 1,
    parameter logic [PN-1:0][AW-1:0] ADR = '0,
    parameter logic [PN-1:0][AW-1:0] MSK = '1,
    parameter int unsigned           CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    tcb_dec_np_if.slave   bus,
    input  logic          cnt_clr,
    output logic [CW-1:0] cnt_unm
);
    localparam int unsigned SW = $clog2(PN);

    if (PN < 2 || PN > 16) begin : g_bad_pn
        $error("tcb_dec_np: PN=%0d outside 2..16", PN);
    end
    if (DLY > 4) begin : g_bad_dly
        $error("tcb_dec_np: DLY=%0d above 4", DLY);
    end
    if (AW != TCB_AW || DW != TCB_DW || BW != TCB_BW) begin : g_bad_width
        $error("tcb_dec_np: bus widths must match tcb_pkg");
    end

    function automatic logic ovl_f();
        logic o;
        o = 1'b0;
        for (int i = 0; i < PN; i++)
            for (int j = i + 1; j < PN; j++)
                if (((ADR[i] ^ ADR[j]) & MSK[i] & MSK[j]) == '0) o = 1'b1;
        return o;
    endfunction

    localparam logic OVERLAP = ovl_f();

    // Overlapping windows are legal (lowest port wins) but usually a config slip.
    always_comb begin
        ovl_chk: assert (!OVERLAP)
            else $warning("tcb_dec_np: overlapping address windows, lowest port wins");
    end

    logic [PN-1:0] hit;
    logic [SW-1:0] sel, sel_d;
    logic          unm, unm_d, act_d, trn;
    logic [SW+1:0] pipe_d, pipe_q;
    tcb_req_t      req;
    tcb_rsp_t      rsp;
    logic [CW-1:0] cnt;

    // Address window match per port.
    always_comb begin
        hit = '0;
        for (int i = 0; i < PN; i++)
            hit[i] = ((bus.sub_adr & MSK[i]) == (ADR[i] & MSK[i]));
    end

    assign sel = SW'(tcb_dec_pri(16'(hit)));
    assign unm = (hit == '0);

    // Unmapped requests are absorbed by the error responder in one cycle.
    assign bus.sub_rdy = unm ? 1'b1 : bus.man_rdy[sel];
    assign trn         = bus.sub_vld & bus.sub_rdy;

    // Only the selected port sees valid.
    always_comb begin
        bus.man_vld = '0;
        if (bus.sub_vld && !unm) bus.man_vld[sel] = 1'b1;
    end

    assign req.wen = bus.sub_wen;
    assign req.ben = bus.sub_ben;
    assign req.adr = bus.sub_adr;
    assign req.wdt = bus.sub_wdt;

    assign bus.man_wen = {PN{req.wen}};
    assign bus.man_ben = {PN{req.ben}};
    assign bus.man_adr = {PN{req.adr}};
    assign bus.man_wdt = {PN{req.wdt}};

    // Gating act with rst discards a transfer taken in a reset cycle (DLY=0 too).
    assign pipe_d = {sel, unm, trn & rst};

    tcb_dly_pipe #(
        .W   (SW + 2),
        .DLY (DLY)
    ) u_pipe (
        .clk (clk),
        .rst (rst),
        .d   (pipe_d),
        .q   (pipe_q)
    );

    assign {sel_d, unm_d, act_d} = pipe_q;

    // Response mux; nothing is reported while reset is asserted.
    always_comb begin
        rsp.rdt = bus.man_rdt[sel_d*DW +: DW];
        rsp.err = 1'b0;
        if (act_d && rst) begin
            if (unm_d) begin
                rsp.rdt = '0;
                rsp.err = 1'b1;
            end else begin
                rsp.err = bus.man_err[sel_d];
            end
        end
    end

    assign bus.sub_rdt = rsp.rdt;
    assign bus.sub_err = rsp.err;

    // Saturating unmapped-access counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (trn && unm && cnt != '1) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign cnt_unm = cnt;
endmodule

// File: tb/tb_tcb_dec_np.sv
// Bench: three decoders (DLY 0, 1, 3) share one stimulus stream; a per-DUT
// queue holds the responses each must produce and the cycle they are due.
module tb_tcb_dec_np;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int PN = 4;
    localparam logic [PN-1:0][AW-1:0] ADR_C =
        {32'h8000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [PN-1:0][AW-1:0] MSK_C = {PN{32'hF000_0000}};

    typedef struct {
        int          due;
        logic [31:0] rdt;
        logic        err;
    } exp_t;

    typedef struct {
        logic        vld;
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  rdy;
        logic [3:0]  exp_vld;
        logic        exp_rdy;
        int          port;
        logic        unm;
    } vec_t;

    logic        clk = 1'b0;
    logic        drv_rst, drv_clr, drv_vld, drv_wen, drv_unm_trn, mon_en;
    logic [31:0] drv_adr;
    logic [3:0]  drv_rdy;
    logic [3:0]  man_err_v = 4'b1100;
    int          dly_v [3] = '{0, 1, 3};
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] cnt_m = '0;
    logic [27:0] cyc_lo;
    logic [PN*DW-1:0] man_rdt_drv;

    logic [15:0] cnt_w   [3];
    logic [31:0] rdt_w   [3];
    logic        err_w   [3];
    logic        rdy_w   [3];
    logic [3:0]  mvld_w  [3];
    logic [31:0] madr3_w [3];

    exp_t sb [3][$];
    vec_t tv [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each subordinate returns its port number and the current cycle.
    assign cyc_lo = cyc[27:0];
    for (genvar i = 0; i < PN; i++) begin : g_rdt
        assign man_rdt_drv[i*DW +: DW] = {4'(i), cyc_lo};
    end

    tcb_dec_np_if #(.AW(AW), .DW(DW), .BW(BW), .PN(PN)) bus [3] ();

    for (genvar j = 0; j < 3; j++) begin : g_dut
        localparam int unsigned D = (j == 0) ? 0 : (j == 1) ? 1 : 3;
        tcb_dec_np #(
            .AW(AW), .DW(DW), .BW(BW), .PN(PN), .DLY(D),
            .ADR(ADR_C), .MSK(MSK_C), .CW(16)
        ) u_dut (
            .clk     (clk),
            .rst     (drv_rst),
            .bus     (bus[j]),
            .cnt_clr (drv_clr),
            .cnt_unm (cnt_w[j])
        );
        assign bus[j].sub_vld = drv_vld;
        assign bus[j].sub_wen = drv_wen;
        assign bus[j].sub_ben = 4'hF;
        assign bus[j].sub_adr = drv_adr;
        assign bus[j].sub_wdt = 32'h1234_5678;
        assign bus[j].man_rdt = man_rdt_drv;
        assign bus[j].man_err = man_err_v;
        assign bus[j].man_rdy = drv_rdy;
        assign rdt_w[j]   = bus[j].sub_rdt;
        assign err_w[j]   = bus[j].sub_err;
        assign rdy_w[j]   = bus[j].sub_rdy;
        assign mvld_w[j]  = bus[j].man_vld;
        assign madr3_w[j] = bus[j].man_adr[3*AW +: AW];
    end

    task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d (DLY=%0d) cyc=%0d: got %h want %h", name, j, dly_v[j], cyc, act, exp);
        end
    endtask

    // One bus cycle; queue the responses the transfer must produce.
    task automatic drive(input logic vld, input logic wen, input logic [31:0] adr,
                         input logic [3:0] rdy, input logic clr, input logic rst_v,
                         input int port, input logic unm);
        logic trn;
        exp_t e;
        int   t;
        @(posedge clk);
        #1;
        drv_vld = vld;
        drv_wen = wen;
        drv_adr = adr;
        drv_rdy = rdy;
        drv_clr = clr;
        drv_rst = rst_v;
        trn = vld && (unm || rdy[port]);
        drv_unm_trn = trn && unm;
        if (rst_v && trn) begin
            for (int j = 0; j < 3; j++) begin
                t = cyc + dly_v[j];
                e.due = t;
                if (unm) begin
                    e.rdt = '0;
                    e.err = 1'b1;
                end else begin
                    e.rdt = {4'(port), t[27:0]};
                    e.err = man_err_v[port];
                end
                sb[j].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 0, 1'b0);
    endtask

    // Response and counter checker, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int j = 0; j < 3; j++) begin
                chk("cnt_unm", j, 32'(cnt_w[j]), 32'(cnt_m));
                if (!drv_rst) begin
                    chk("rst_err", j, 32'(err_w[j]), 32'd0);
                    sb[j].delete();
                end else if (sb[j].size() > 0 && sb[j][0].due == cyc) begin
                    e = sb[j].pop_front();
                    chk("rsp_rdt", j, rdt_w[j], e.rdt);
                    chk("rsp_err", j, 32'(err_w[j]), 32'(e.err));
                end else begin
                    chk("idle_err", j, 32'(err_w[j]), 32'd0);
                end
            end
        end else begin
            for (int j = 0; j < 3; j++) sb[j].delete();
        end
        if (!drv_rst)                          cnt_m = '0;
        else if (drv_clr)                      cnt_m = '0;
        else if (drv_unm_trn && cnt_m != '1)   cnt_m = cnt_m + 16'd1;
    end

    initial begin
        drv_rst = 1'b0; drv_clr = 1'b0; drv_vld = 1'b0; drv_wen = 1'b0;
        drv_adr = '0;   drv_rdy = 4'hF; drv_unm_trn = 1'b0; mon_en = 1'b0;

        //            vld  wen  adr            rdy      exp_vld  rdy  port unm
        tv[0]  = '{1'b1, 1'b0, 32'h1000_0004, 4'hF,   4'b0010, 1'b1, 1, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 32'h0000_0000, 4'hF,   4'b0001, 1'b1, 0, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 32'h2000_0000, 4'hF,   4'b0100, 1'b1, 2, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 32'h8000_0010, 4'hF,   4'b1000, 1'b1, 3, 1'b0};
        tv[4]  = '{1'b1, 1'b1, 32'h5000_0000, 4'hF,   4'b0000, 1'b1, 0, 1'b1};
        tv[5]  = '{1'b0, 1'b0, 32'h0000_0000, 4'hF,   4'b0000, 1'b1, 0, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 32'h2000_0008, 4'b1011, 4'b0100, 1'b0, 2, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 32'h2000_0008, 4'b1011, 4'b0100, 1'b0, 2, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 32'h2000_0008, 4'b1011, 4'b0100, 1'b0, 2, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 32'h2000_0008, 4'hF,   4'b0100, 1'b1, 2, 1'b0};
        tv[10] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF,   4'b0000, 1'b1, 0, 1'b0};
        tv[11] = '{1'b1, 1'b0, 32'h8000_0000, 4'b0111, 4'b1000, 1'b0, 3, 1'b0};
        tv[12] = '{1'b1, 1'b1, 32'hF000_0000, 4'b0111, 4'b0000, 1'b1, 0, 1'b1};
        tv[13] = '{1'b0, 1'b0, 32'h1000_0000, 4'hF,   4'b0000, 1'b1, 1, 1'b0};
        tv[14] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF,   4'b0000, 1'b1, 0, 1'b0};
        tv[15] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF,   4'b0000, 1'b1, 0, 1'b0};

        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        mon_en = 1'b1;

        idle(1);
        @(negedge clk);
        for (int j = 0; j < 3; j++) chk("reset_man_vld", j, 32'(mvld_w[j]), 32'd0);

        for (int v = 0; v < 16; v++) begin
            drive(tv[v].vld, tv[v].wen, tv[v].adr, tv[v].rdy, 1'b0, 1'b1, tv[v].port, tv[v].unm);
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                chk("man_vld", j, 32'(mvld_w[j]), 32'(tv[v].exp_vld));
                chk("sub_rdy", j, 32'(rdy_w[j]), 32'(tv[v].exp_rdy));
                chk("man_adr", j, madr3_w[j], tv[v].adr);
            end
        end
        idle(1);
        @(negedge clk);
        for (int j = 0; j < 3; j++) chk("cnt_after_table", j, 32'(cnt_w[j]), 32'd2);

        // Saturation, then clear racing an unmapped transfer.
        drive(1'b0, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 0, 1'b0);
        for (int n = 0; n < 65540; n++) drive(1'b1, 1'b1, 32'h5000_0000, 4'hF, 1'b0, 1'b1, 0, 1'b1);
        idle(1);
        @(negedge clk);
        for (int j = 0; j < 3; j++) chk("cnt_sat", j, 32'(cnt_w[j]), 32'h0000_FFFF);
        drive(1'b1, 1'b1, 32'h5000_0000, 4'hF, 1'b1, 1'b1, 0, 1'b1);
        idle(1);
        @(negedge clk);
        for (int j = 0; j < 3; j++) chk("cnt_clr_wins", j, 32'(cnt_w[j]), 32'd0);
        idle(4);

        // Unmapped transfer, then reset (with a transfer inside the reset cycle).
        drive(1'b1, 1'b1, 32'h6000_0000, 4'hF, 1'b0, 1'b1, 0, 1'b1);
        drive(1'b1, 1'b1, 32'h6000_0000, 4'hF, 1'b0, 1'b0, 0, 1'b1);
        idle(4);
        @(negedge clk);
        for (int j = 0; j < 3; j++) chk("cnt_after_rst", j, 32'(cnt_w[j]), 32'd0);
        for (int j = 0; j < 3; j++) chk("sb_drained", j, 32'(sb[j].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tcb_dec_np.md
Name: tcb_dec_np

Overview:
- Parametrised TCB address decoder: one subordinate port, PN manager ports.
- Successor of the fixed 3-port decoder, with these additions:
  - any port count;
  - a configurable response delay (DLY) with a select pipeline;
  - a built-in error responder for unmapped addresses;
  - a saturating unmapped-access counter.
- Sits between a CPU/DMA manager and memory/peripheral subordinates in the SoC interconnect.

Parameters:
- AW, 32, address width
- DW, 32, data width
- BW, DW/8, byte-enable width
- PN, 4, number of manager ports (2..16)
- DLY, 1, response delay in cycles after transfer (0..4); must match all attached subordinates
- ADR, PN x AW all-zero, per-port base address
- MSK, PN x AW all-ones, per-port address mask
- CW, 16, unmapped-access counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- sub_vld  in  1  request valid
- sub_wen  in  1  write enable
- sub_ben  in  BW  byte enables
- sub_adr  in  AW  address
- sub_wdt  in  DW  write data
- sub_rdt  out  DW  read data (response phase)
- sub_err  out  1  error (response phase)
- sub_rdy  out  1  ready (request phase)
- man_vld  out  PN  per-port valid
- man_wen  out  PN  per-port write enable
- man_ben  out  PN*BW  per-port byte enables
- man_adr  out  PN*AW  per-port address
- man_wdt  out  PN*DW  per-port write data
- man_rdt  in  PN*DW  per-port read data
- man_err  in  PN  per-port error
- man_rdy  in  PN  per-port ready
- cnt_clr  in  1  clear unmapped counter
- cnt_unm  out  CW  unmapped-access count

Behaviour:
- Transfer: trn = sub_vld & sub_rdy.
- Decode: hit[i] = (sub_adr & MSK[i]) == (ADR[i] & MSK[i]).
  - Lowest index with hit wins (fixed priority; overlap is legal but flagged by a simulation-only warning at elaboration).
  - unm = no hit.
- Request path, combinational, zero latency:
  - man_vld[i] = sub_vld & (sel==i) & !unm.
  - wen/ben/adr/wdt are broadcast to all ports unconditionally.
  - sub_rdy = unm ? 1 : man_rdy[sel]. Unmapped requests complete immediately.
- Response pipeline: DLY-stage shift register of {sel, unm, act}, where act = trn. Stage 0 loads every cycle; entries shift every cycle regardless of traffic (fixed-delay bus).
- Response mux uses stage DLY-1 (DLY=0: current-cycle sel/unm, purely combinational):
  - Mapped: sub_rdt = man_rdt[sel_d], sub_err = man_err[sel_d].
  - Unmapped: sub_rdt = 0, sub_err = 1.
  - Response is valid only when act_d=1. Otherwise sub_err=0 and sub_rdt = man_rdt[sel_d].
- Back-to-back transfers to different ports, each cycle, must each return their own port's data exactly DLY cycles later.
- Counter:
  - Increments on trn & unm; saturates at 2^CW-1.
  - cnt_clr has priority over increment (clear wins when simultaneous).
- Reset (rst==0 at clk edge):
  - All pipeline stages go to {sel=0, unm=0, act=0}; cnt_unm=0.
  - Combinational outputs follow inputs.
  - A transfer accepted in the reset cycle is discarded: no error response, no count.
  - Reset mid-flight flushes pending responses; sub_err must not assert for them.
- Illegal: DLY>4 or PN<2 gives an elaboration error.

Decomposition:
- Package tcb_pkg:
  - tcb_req_t struct {wen, ben, adr, wdt};
  - tcb_rsp_t struct {rdt, err};
  - function tcb_dec_pri(hit vector) -> index, lowest-first.
- Sub-module tcb_dly_pipe: generic DLY-stage shift register with sync active-low reset and a DLY=0 pass-through. Instantiated once for {sel, unm, act}.

Test Plan:
- Setup: PN=4, DLY=1, MSK[all]=0xF000_0000, ADR={0x0000_0000, 0x1000_0000, 0x2000_0000, 0x8000_0000}.
- Read 0x1000_0004, port1 rdt=0xCAFE_0001 -> man_vld=4'b0010; next cycle sub_rdt=0xCAFE_0001, sub_err=0.
- Back-to-back reads 0x0000_0000, 0x2000_0000, 0x8000_0010 -> three responses in consecutive cycles carrying ports 0, 2, 3 data in order.
- Write 0x5000_0000 (unmapped) -> man_vld=0, sub_rdy=1 same cycle; next cycle sub_err=1, sub_rdt=0; cnt_unm=1.
- Port2 man_rdy=0 for 3 cycles, then 1 -> sub_rdy low 3 cycles; single response 1 cycle after the rdy cycle; no duplicate.
- Counter: 65540 unmapped transfers (CW=16) -> cnt_unm holds 0xFFFF; cnt_clr asserted together with an unmapped transfer -> cnt_unm=0.
- Unmapped transfer, then rst=0 in the following cycle -> sub_err stays 0; cnt_unm=0. Repeat all of the above with DLY=0 and DLY=3 and check timing shifts accordingly.
